// File: rtl/ac97_csr_responder_pkg.sv
// Shared definitions for the AC97 CSR responder: register offsets,
// CTRL bit positions and the DMA channel state type.
package ac97_pkg;

    // Register byte offsets on the CSR bus
    localparam logic [13:0] AC97_CTRL = 14'h00;
    localparam logic [13:0] DMAW_CTRL = 14'h10;
    localparam logic [13:0] DMAW_ADDR = 14'h14;
    localparam logic [13:0] DMAW_CNT  = 14'h18;
    localparam logic [13:0] DMAR_CTRL = 14'h20;
    localparam logic [13:0] DMAR_ADDR = 14'h24;
    localparam logic [13:0] DMAR_CNT  = 14'h28;

    // Global CTRL bits
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Channel CTRL bits
    localparam int CH_START_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } ch_state_t;

endpackage

// File: rtl/ac97_csr_responder_if.sv
// CSR write bus plus the two DMA request/ack channels of the AC97 responder.
// master: controller / memory side, slave: the responder.
interface ac97_csr_responder_if #(
    parameter int DMA_AW = 32
);
    logic [13:0]       csr_addr;
    logic              csr_we;
    logic [31:0]       csr_di;
    logic [31:0]       csr_do;
    logic              dmar_req;
    logic              dmaw_req;
    logic [DMA_AW-1:0] dmar_addr;
    logic [DMA_AW-1:0] dmaw_addr;
    logic              dmar_ack;
    logic              dmaw_ack;
    logic              dmar_irq;
    logic              dmaw_irq;

    modport master (
        output csr_addr, csr_we, csr_di, dmar_ack, dmaw_ack,
        input  csr_do, dmar_req, dmaw_req, dmar_addr, dmaw_addr, dmar_irq, dmaw_irq
    );

    modport slave (
        input  csr_addr, csr_we, csr_di, dmar_ack, dmaw_ack,
        output csr_do, dmar_req, dmaw_req, dmar_addr, dmaw_addr, dmar_irq, dmaw_irq
    );
endinterface

// File: rtl/ac97_csr_responder_dma_channel.sv
// One DMA channel: ADDR/CNT registers, IDLE/XFER/DONE sequencer,
// completion-pending flag and the word req/ack handshake.
module ac97_dma_channel
    import ac97_pkg::*;
#(
    parameter int DMA_AW = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,    // global enable including a same-cycle CTRL write
    input  logic              ctrl_we,
    input  logic              start,
    input  logic              addr_we,
    input  logic              cnt_we,
    input  logic [31:0]       wdata,
    input  logic              ack,
    output logic              req,
    output logic [DMA_AW-1:0] addr,
    output logic [CNT_W-1:0]  cnt,
    output logic              busy,
    output logic              pending
);

    ch_state_t         state_reg;
    logic              req_reg;
    logic              pending_reg;
    logic [DMA_AW-1:0] addr_reg;
    logic [CNT_W-1:0]  cnt_reg;

    // Channel sequencer; ADDR/CNT are only writable while the channel is idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            req_reg     <= 1'b0;
            pending_reg <= 1'b0;
            addr_reg    <= '0;
            cnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (addr_we)
                        addr_reg <= DMA_AW'(wdata) & ~DMA_AW'(32'd3);
                    if (cnt_we)
                        cnt_reg <= CNT_W'(wdata);
                    if (ctrl_we) begin
                        pending_reg <= 1'b0;
                        if (start && enable) begin
                            if (cnt_reg != '0) begin
                                state_reg <= XFER;
                                req_reg   <= 1'b1;
                            end else begin
                                // empty transfer completes without a request
                                state_reg <= DONE;
                            end
                        end
                    end
                end
                XFER: begin
                    // an accepted word is always counted, even when aborted this cycle
                    if (ack) begin
                        addr_reg <= addr_reg + DMA_AW'(32'd4);
                        cnt_reg  <= cnt_reg - CNT_W'(1);
                    end
                    if (ctrl_we)
                        pending_reg <= 1'b0;
                    if ((ctrl_we && !start) || !enable) begin
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
                    end else if (ack && cnt_reg == CNT_W'(1)) begin
                        state_reg <= DONE;
                        req_reg   <= 1'b0;
                    end
                end
                DONE: begin
                    // completion beats any CTRL write landing in this cycle
                    state_reg   <= IDLE;
                    pending_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign req     = req_reg;
    assign addr    = addr_reg;
    assign cnt     = cnt_reg;
    assign pending = pending_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: rtl/ac97_csr_responder.sv
// AC97 CSR responder top: global CTRL register, CSR address decode,
// two DMA channels (index 0 = record/dmaw, 1 = playback/dmar), irq
// registers and the optional read mux.
// Optional feature macro: AC97_CSR_READBACK_EN (registered csr_do readback;
// when undefined csr_do is tied to 0).
module ac97_csr_responder
    import ac97_pkg::*;
#(
    parameter int DMA_AW = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ac97_csr_responder_if.slave  bus
);

    logic [1:0]        ctrl_reg;
    logic [1:0]        ctrl_next;
    logic              ctrl_we;
    logic [1:0]        irq_reg;

    logic              ch_req     [2];
    logic [DMA_AW-1:0] ch_addr    [2];
    logic [CNT_W-1:0]  ch_cnt     [2];
    logic              ch_busy    [2];
    logic              ch_pending [2];
    logic              ch_ack     [2];

    assign ctrl_we   = bus.csr_we && (bus.csr_addr == AC97_CTRL);
    // channels see the enable value taking effect at this edge so that
    // clearing it aborts a transfer on the same edge
    assign ctrl_next = ctrl_we ? bus.csr_di[1:0] : ctrl_reg;

    // Global CTRL register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ctrl_reg <= 2'b00;
        else
            ctrl_reg <= ctrl_next;
    end

    assign ch_ack[0] = bus.dmaw_ack;
    assign ch_ack[1] = bus.dmar_ack;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            localparam logic [13:0] CTRL_OFS = (gi == 0) ? DMAW_CTRL : DMAR_CTRL;
            localparam logic [13:0] ADDR_OFS = (gi == 0) ? DMAW_ADDR : DMAR_ADDR;
            localparam logic [13:0] CNT_OFS  = (gi == 0) ? DMAW_CNT  : DMAR_CNT;

            ac97_dma_channel #(
                .DMA_AW (DMA_AW),
                .CNT_W  (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .enable  (ctrl_next[CTRL_ENABLE_BIT]),
                .ctrl_we (bus.csr_we && (bus.csr_addr == CTRL_OFS)),
                .start   (bus.csr_di[CH_START_BIT]),
                .addr_we (bus.csr_we && (bus.csr_addr == ADDR_OFS)),
                .cnt_we  (bus.csr_we && (bus.csr_addr == CNT_OFS)),
                .wdata   (bus.csr_di),
                .ack     (ch_ack[gi]),
                .req     (ch_req[gi]),
                .addr    (ch_addr[gi]),
                .cnt     (ch_cnt[gi]),
                .busy    (ch_busy[gi]),
                .pending (ch_pending[gi])
            );
        end
    endgenerate

    // Registered interrupt lines: pending gated by the global irq enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            irq_reg <= 2'b00;
        else
            irq_reg <= {ch_pending[1], ch_pending[0]} & {2{ctrl_reg[CTRL_IRQ_EN_BIT]}};
    end

    assign bus.dmaw_req  = ch_req[0];
    assign bus.dmar_req  = ch_req[1];
    assign bus.dmaw_addr = ch_addr[0];
    assign bus.dmar_addr = ch_addr[1];
    assign bus.dmaw_irq  = irq_reg[0];
    assign bus.dmar_irq  = irq_reg[1];

`ifdef AC97_CSR_READBACK_EN
    logic [31:0] rd_data;
    logic [31:0] csr_do_reg;

    // Read mux; channel CTRL reads return {pending, busy}
    always_comb begin
        rd_data = '0;
        case (bus.csr_addr)
            AC97_CTRL: rd_data = {30'b0, ctrl_reg};
            DMAW_CTRL: rd_data = {30'b0, ch_pending[0], ch_busy[0]};
            DMAW_ADDR: rd_data = 32'(ch_addr[0]);
            DMAW_CNT:  rd_data = 32'(ch_cnt[0]);
            DMAR_CTRL: rd_data = {30'b0, ch_pending[1], ch_busy[1]};
            DMAR_ADDR: rd_data = 32'(ch_addr[1]);
            DMAR_CNT:  rd_data = 32'(ch_cnt[1]);
            default:   rd_data = '0;
        endcase
    end

    // One-cycle read pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            csr_do_reg <= '0;
        else
            csr_do_reg <= rd_data;
    end

    assign bus.csr_do = csr_do_reg;
`else
    assign bus.csr_do = '0;

    // counters and busy flags only feed the read mux
    logic unused_readback;
    assign unused_readback = ^{ch_cnt[0], ch_cnt[1], ch_busy[0], ch_busy[1]};
`endif

endmodule

// File: tb/tb_ac97_csr_responder.sv
// Self-checking bench for ac97_csr_responder: directed scenarios followed by
// randomized CSR writes and acks, compared every cycle against a
// word-level reference model of both channels.
module tb_ac97_csr_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ac97_csr_responder_if #(.DMA_AW(32)) bus ();

    ac97_csr_responder #(
        .DMA_AW (32),
        .CNT_W  (16)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model, index 0 = record (dmaw), 1 = playback (dmar)
    logic [31:0] m_addr [2];
    logic [15:0] m_cnt  [2];
    bit          m_xfer [2];   // words outstanding, request raised
    bit          m_fin  [2];   // completion cycle before the flag is posted
    bit          m_pend [2];
    bit          m_irq  [2];
    logic [1:0]  m_ctrl;
    logic [31:0] m_do;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [13:0] a);
        logic [31:0] v;
        v = 32'h0;
`ifdef AC97_CSR_READBACK_EN
        case (a)
            14'h00: v = {30'b0, m_ctrl};
            14'h10: v = {30'b0, m_pend[0], m_xfer[0] | m_fin[0]};
            14'h14: v = m_addr[0];
            14'h18: v = {16'b0, m_cnt[0]};
            14'h20: v = {30'b0, m_pend[1], m_xfer[1] | m_fin[1]};
            14'h24: v = m_addr[1];
            14'h28: v = {16'b0, m_cnt[1]};
            default: v = 32'h0;
        endcase
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_addr[c] = 0; m_cnt[c] = 0; m_xfer[c] = 0;
            m_fin[c]  = 0; m_pend[c] = 0; m_irq[c] = 0;
        end
        m_ctrl = 2'b00;
        m_do   = 32'h0;
    endtask

    // Advance the model by one clock edge with the given bus inputs
    task automatic model_step(input bit we, input logic [13:0] a, input logic [31:0] di,
                              input bit ackw, input bit ackr);
        logic [1:0]  ctrl_new;
        logic [13:0] base;
        bit          ack [2];
        bit          wc, wa, wn, last;
        m_do     = model_read(a);
        m_irq[0] = m_pend[0] & m_ctrl[1];
        m_irq[1] = m_pend[1] & m_ctrl[1];
        ctrl_new = (we && a == 14'h00) ? di[1:0] : m_ctrl;
        ack[0]   = ackw;
        ack[1]   = ackr;
        for (int c = 0; c < 2; c++) begin
            base = (c == 0) ? 14'h10 : 14'h20;
            wc = we && (a == base);
            wa = we && (a == base + 14'h4);
            wn = we && (a == base + 14'h8);
            if (m_fin[c]) begin
                m_fin[c]  = 0;
                m_pend[c] = 1;
            end else if (m_xfer[c]) begin
                last = ack[c] && (m_cnt[c] == 16'd1);
                if (ack[c]) begin
                    m_addr[c] = m_addr[c] + 32'd4;
                    m_cnt[c]  = m_cnt[c] - 16'd1;
                end
                if (wc) m_pend[c] = 0;
                if ((wc && !di[0]) || !ctrl_new[0]) begin
                    m_xfer[c] = 0;
                end else if (last) begin
                    m_xfer[c] = 0;
                    m_fin[c]  = 1;
                end
            end else begin
                if (wa) m_addr[c] = di & ~32'd3;
                if (wn) m_cnt[c]  = di[15:0];
                if (wc) begin
                    m_pend[c] = 0;
                    if (di[0] && ctrl_new[0]) begin
                        if (m_cnt[c] != 0) m_xfer[c] = 1;
                        else               m_fin[c]  = 1;
                    end
                end
            end
        end
        m_ctrl = ctrl_new;
    endtask

    task automatic check_outputs();
        check("dmaw_req",  {31'b0, bus.dmaw_req}, {31'b0, m_xfer[0]});
        check("dmar_req",  {31'b0, bus.dmar_req}, {31'b0, m_xfer[1]});
        check("dmaw_addr", bus.dmaw_addr, m_addr[0]);
        check("dmar_addr", bus.dmar_addr, m_addr[1]);
        check("dmaw_irq",  {31'b0, bus.dmaw_irq}, {31'b0, m_irq[0]});
        check("dmar_irq",  {31'b0, bus.dmar_irq}, {31'b0, m_irq[1]});
        check("csr_do",    bus.csr_do, m_do);
    endtask

    // One clock: check state from the last edge, then drive the next inputs
    task automatic cycle(input bit we, input logic [13:0] a, input logic [31:0] di,
                         input bit ackw, input bit ackr);
        @(negedge clk);
        check_outputs();
        bus.csr_we   = we;
        bus.csr_addr = a;
        bus.csr_di   = di;
        bus.dmaw_ack = ackw;
        bus.dmar_ack = ackr;
        if (we)
            $display("t=%0t wr 0x%02h <= 0x%08h ackw=%0d ackr=%0d", $time, a, di, ackw, ackr);
        model_step(we, a, di, ackw, ackr);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        cycle(1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [13:0] a);
        cycle(1'b0, a, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 14'h00, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        $display("t=%0t reset asserted", $time);
        @(negedge clk);
        bus.csr_we = 0; bus.csr_addr = 0; bus.csr_di = 0;
        bus.dmaw_ack = 0; bus.dmar_ack = 0;
        rst_n = 1'b1;
        model_step(1'b0, 14'h00, 32'h0, 1'b0, 1'b0);
    endtask

    logic [13:0] addr_list [9];

    initial begin
        bus.csr_we = 0; bus.csr_addr = 0; bus.csr_di = 0;
        bus.dmaw_ack = 0; bus.dmar_ack = 0;
        model_reset();
        addr_list = '{14'h00, 14'h10, 14'h14, 14'h18, 14'h20, 14'h24, 14'h28, 14'h2C, 14'h04};

        // Reset state and readback of all registers
        do_reset();
        for (int i = 0; i < 7; i++) rd(addr_list[i]);
        idle(1);

        // Playback: three words acked back to back
        wr(14'h00, 32'h3);
        wr(14'h24, 32'h1000);
        wr(14'h28, 32'd3);
        wr(14'h20, 32'h1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 14'h00, 32'h0, 1'b0, 1'b1);
        idle(3);
        check("play_irq",  {31'b0, bus.dmar_irq}, 32'h1);
        check("play_addr", bus.dmar_addr, 32'h100C);
        rd(14'h24);
        idle(1);

        // Record: address wraps past the top of the space
        wr(14'h14, 32'hFFFF_FFFC);
        wr(14'h18, 32'd2);
        wr(14'h10, 32'h1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 14'h00, 32'h0, 1'b1, 1'b0);
        idle(3);
        check("rec_irq",  {31'b0, bus.dmaw_irq}, 32'h1);
        check("rec_wrap", bus.dmaw_addr, 32'h4);
        wr(14'h10, 32'h0);
        idle(2);
        check("rec_irq_clr", {31'b0, bus.dmaw_irq}, 32'h0);

        // Zero-length start, then with irq enable off
        wr(14'h28, 32'd0);
        wr(14'h20, 32'h1);
        idle(3);
        check("zero_irq", {31'b0, bus.dmar_irq}, 32'h1);
        check("zero_req", {31'b0, bus.dmar_req}, 32'h0);
        wr(14'h00, 32'h1);
        wr(14'h20, 32'h1);
        idle(3);
        check("masked_irq", {31'b0, bus.dmar_irq}, 32'h0);
        rd(14'h20);
        idle(1);

        // Abort in the same cycle as the third ack
        wr(14'h00, 32'h3);
        wr(14'h24, 32'h2000);
        wr(14'h28, 32'd5);
        wr(14'h20, 32'h1);
        cycle(1'b0, 14'h00, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 14'h00, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 14'h20, 32'h0, 1'b0, 1'b1);
        idle(3);
        check("abort_req",  {31'b0, bus.dmar_req}, 32'h0);
        check("abort_irq",  {31'b0, bus.dmar_irq}, 32'h0);
        check("abort_addr", bus.dmar_addr, 32'h200C);
        rd(14'h28);
        idle(1);

        // Both channels with interleaved acks
        wr(14'h14, 32'h0000_4000);
        wr(14'h18, 32'd4);
        wr(14'h24, 32'h0000_8001);
        wr(14'h28, 32'd5);
        wr(14'h10, 32'h1);
        wr(14'h20, 32'h1);
        for (int i = 0; i < 30; i++)
            cycle(1'b0, addr_list[$urandom_range(0, 6)], 32'h0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(4);

        // Reset in the middle of a transfer with an ack in flight
        wr(14'h00, 32'h3);
        wr(14'h18, 32'd4);
        wr(14'h10, 32'h1);
        cycle(1'b0, 14'h00, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 14'h00, 32'h0, 1'b1, 1'b0);
        do_reset();
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [13:0] a;
            logic [31:0] d;
            bit          we;
            a  = addr_list[$urandom_range(0, 8)];
            we = ($urandom_range(0, 3) == 0);
            d  = $urandom;
            if (a == 14'h18 || a == 14'h28) d = $urandom_range(0, 6);
            if (a == 14'h00) d = {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)};
            if ($urandom_range(0, 15) == 0) d = 32'hFFFF_FFF8;
            cycle(we, a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
